// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl: turns raw PS/2 scancode bytes into make/break events.
// The byte strobe is synchronised into clk and edge-detected. An E0/F0 prefix
// FSM with a timeout decodes the bytes. Decoded events wait in a
// first-word-fall-through FIFO. The block also tracks the key that is held down.
// Optional build macro PS2_TYPEMATIC_FILTER_EN: typematic repeats of the held
// key are not pushed to the FIFO.
module ps2_key_event_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          code_strobe,
  input  logic [7:0]                    scancode,
  input  logic                          evt_ready,
  input  logic                          ovf_clr,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_break,
  output logic                          evt_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          proto_err,
  output logic [7:0]                    held_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   DEPTH_L = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  logic          s1_q, s2_q, s3_q;
  logic          rise;
  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          emit, emit_brk, emit_ext, perr_d;
  logic          push_req, pop, accept, drop;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d, perr_q;
  logic [7:0]    held_q, held_d;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    head;

  // Two-flop synchroniser plus a delay flop, so that a strobe held high gives a single rise
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= code_strobe;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Prefix FSM state and timeout counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Prefix decoding: a rise takes priority over the timeout
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    emit_brk = 1'b0;
    emit_ext = 1'b0;
    perr_d   = 1'b0;
    if (rise) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          if (scancode == 8'hE0)      state_d = EXT;
          else if (scancode == 8'hF0) state_d = BRK;
          else                        emit = 1'b1;
        end
        EXT: begin
          if (scancode == 8'hF0)      state_d = EXT_BRK;
          else if (scancode != 8'hE0) begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        BRK: begin
          if (scancode == 8'hE0) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else if (scancode != 8'hF0) begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            state_d  = IDLE;
          end
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (scancode == 8'hE0 || scancode == 8'hF0) begin
            perr_d = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
            emit_ext = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  assign push_req = emit & ~(~emit_brk & (scancode == held_q));
`else
  assign push_req = emit;
`endif

  assign pop    = (level_q != '0) & evt_ready;
  assign accept = push_req & ((level_q < DEPTH_L) | pop);
  assign drop   = push_req & ~accept;

  // FIFO bookkeeping, the overflow flag and the held-key tracker
  always_comb begin
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (accept && !pop)      level_d = level_q + 1'b1;
    else if (!accept && pop) level_d = level_q - 1'b1;
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    held_d = held_q;
    if (emit) begin
      if (!emit_brk)               held_d = scancode;
      else if (scancode == held_q) held_d = 8'h00;
    end
  end

  // Control registers: pointers, level, flags, held key
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      perr_q   <= 1'b0;
      held_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      perr_q   <= perr_d;
      held_q   <= held_d;
    end
  end

  // Event storage; the level counter tells which entries are valid, so storage needs no reset
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {scancode, emit_brk, emit_ext};
  end

  assign head       = mem_q[rd_ptr_q];
  assign evt_valid  = (level_q != '0);
  assign evt_code   = evt_valid ? head[9:2] : 8'h00;
  assign evt_break  = evt_valid & head[1];
  assign evt_ext    = evt_valid & head[0];
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign proto_err  = perr_q;
  assign held_code  = held_q;

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sequences raw scancode bytes from the PS/2 receiver into decoded key events (make/break, extended) and buffers them in a small FIFO for downstream consumers (7-seg display, VGA text logic).
- Synchronises the receiver's byte strobe into the `clk` domain, runs the E0/F0 prefix state machine with a prefix timeout, and tracks the currently held key.
- Sits between the PS/2 interface and any display/consumer block.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, >=2. AW = log2(FIFO_DEPTH).
- TIMEOUT_CYCLES, 100000, clk cycles allowed in a prefix state before abandoning the sequence; >=2.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- code_strobe  input  1  byte-valid level from PS/2 receiver; asynchronous to clk
- scancode  input  8  received byte; stable >=4 clk cycles before and while code_strobe high
- evt_ready  input  1  consumer accepts head event
- ovf_clr  input  1  clears overflow flag
- evt_valid  output  1  FIFO non-empty
- evt_code  output  8  head event scancode (prefixes stripped)
- evt_break  output  1  head event is a key release
- evt_ext  output  1  head event had E0 prefix
- fifo_level  output  AW+1  entries stored, 0..FIFO_DEPTH
- overflow  output  1  sticky: an event was dropped on full FIFO
- proto_err  output  1  one-cycle pulse on illegal prefix sequence
- held_code  output  8  scancode of last pressed, unreleased key; 0x00 if none

Behaviour:
- Reset (reset=0 at a clk edge):
  - evt_valid=0, fifo_level=0, overflow=0, proto_err=0, held_code=0x00.
  - evt_code/evt_break/evt_ext=0.
  - FSM=IDLE; sync flops and timeout counter cleared.
  - A reset mid-sequence discards the partial prefix and all FIFO contents.
- Strobe path:
  - 2-flop synchroniser s1, s2, then delay flop s3; rise = s2 & ~s3.
  - One rise = one byte; strobe held high yields exactly one byte.
  - scancode is sampled on the clk edge where rise=1.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Each rise is processed as follows:
  - IDLE: E0 -> EXT; F0 -> BRK; other -> emit make (ext=0), stay IDLE.
  - EXT: E0 -> stay EXT (repeated prefix ignored); F0 -> EXT_BRK; other -> emit make (ext=1) -> IDLE.
  - BRK: F0 -> stay BRK; E0 -> proto_err pulse, -> IDLE, no emit; other -> emit break (ext=0) -> IDLE.
  - EXT_BRK: E0 or F0 -> proto_err pulse, -> IDLE; other -> emit break (ext=1) -> IDLE.
- Timeout:
  - Counter resets on every rise and on entering IDLE; counts while in EXT/BRK/EXT_BRK.
  - On reaching TIMEOUT_CYCLES-1 the FSM -> IDLE silently; no emit, no proto_err.
- Emit = push {code, break, ext} into FIFO at the same edge rise is consumed.
- Latency: code_strobe first sampled high at edge 0 -> push at edge 2 -> evt_valid=1 after edge 2 (empty FIFO, non-prefix byte).
- FIFO:
  - First-word-fall-through; head fields valid whenever evt_valid=1.
  - Pop when evt_valid & evt_ready.
  - Push accepted if fifo_level<FIFO_DEPTH or a pop occurs in the same cycle.
  - Simultaneous push+pop: level unchanged.
  - Push when full without pop: event dropped, overflow<=1.
  - evt_ready while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow:
  - Cleared by ovf_clr=1.
  - If ovf_clr coincides with a drop, overflow stays 1 (set wins).
- held_code:
  - Updated on every emit, independent of FIFO acceptance.
  - On make: held_code<=code.
  - On break: held_code<=0x00 only if code equals held_code; otherwise unchanged.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A make whose code equals held_code (typematic repeat) is not pushed to the FIFO.
  - held_code is unchanged; the FSM still returns to IDLE normally.
- Undefined: every make is pushed, including repeats.

Test Plan:
- Reset, then strobe byte 0x1C (high 10 cycles) with evt_ready=0 -> after edge 2 evt_valid=1, evt_code=0x1C, break=0, ext=0, fifo_level=1, held_code=0x1C.
- Bytes F0,1C, then E0,75, then E0,F0,75 -> events {1C,brk=1,ext=0}, {75,0,1}, {75,1,1}, in order; held_code 0x00 -> 0x75 -> 0x00.
- evt_ready=0, send FIFO_DEPTH+1 make codes 0x01..0x09 -> fifo_level=8, overflow=1, head still 0x01; pulse ovf_clr -> overflow=0.
- Send F0 then E0 -> one proto_err pulse, no event. Send E0 then wait TIMEOUT_CYCLES, then 0x1C -> event {1C,0,0}, proto_err never pulses.
- FIFO full, evt_ready=1 while a new byte 0x2A arrives -> push and pop in the same cycle, fifo_level stays 8, 0x2A becomes the tail.
- With PS2_TYPEMATIC_FILTER_EN: 0x1C sent 3 times -> exactly one event. Without the macro -> three events.
